// File: rtl/red_arb.sv
// red_arb: round-robin arbitration of NREQ requesters onto one shared 128-to-64 Goldilocks reducer.
// Optional RED_ARB_STATS_EN adds per-requester transfer counters and a stall-cycle counter.
module red_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*128-1:0]      req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic [127:0]             red_p_o,
  output logic                     red_ce_o,
  input  logic [63:0]              red_r_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_data_o,
`ifdef RED_ARB_STATS_EN
  output logic [NREQ*32-1:0]       stats_acc_o,
  output logic [31:0]              stats_stall_o,
`endif
  output logic [$clog2(NREQ)-1:0]  out_id_o
);
  localparam int IW = $clog2(NREQ);
  logic any, xfer;
  logic [IW-1:0] g, idx, rr_q;
  logic [LAT-1:0] tv_q;
  logic [LAT-1:0][IW-1:0] tid_q;
  logic [NREQ-1:0][127:0] rd;
  logic [127:0] p_q;
  assign rd = req_data_i;
  // walk downward so the index closest to rr_q is the last (winning) assignment
  always_comb begin
    g = rr_q;
    idx = rr_q;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % NREQ);
      if (req_valid_i[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  assign out_valid_o = tv_q[LAT-1];
  assign out_id_o    = tid_q[LAT-1];
  assign out_data_o  = red_r_i;
  assign red_ce_o    = ~(out_valid_o & ~out_ready_i);
  // ready is gated by rst_i directly so nothing is accepted while reset is held
  assign xfer        = any & red_ce_o & ~rst_i;
  assign req_ready_o = xfer ? (NREQ'(1) << g) : '0;
  assign red_p_o     = any ? rd[g] : p_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tv_q  <= '0;
      tid_q <= '0;
      rr_q  <= '0;
      p_q   <= '0;
    end else begin
      if (any) p_q <= rd[g];
      if (red_ce_o) begin
        tv_q  <= LAT'({tv_q, xfer});
        tid_q <= (LAT*IW)'({tid_q, g});
        if (xfer) rr_q <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
      end
    end
`ifdef RED_ARB_STATS_EN
  logic [NREQ-1:0][31:0] acc_q;
  assign stats_acc_o = acc_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      acc_q         <= '0;
      stats_stall_o <= '0;
    end else begin
      if (!red_ce_o) stats_stall_o <= stats_stall_o + 1'b1;
      if (xfer) acc_q[g] <= acc_q[g] + 1'b1;
    end
`endif
endmodule

// File: tb/tb_red_arb.sv
// tb_red_arb: directed and randomized checks of red_arb against a scoreboard and a behavioural reducer.
module tb_red_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 6;
  localparam logic [63:0] P64 = 64'hFFFF_FFFF_0000_0001;
  logic clk_i, rst_i, red_ce_o, out_valid_o, out_ready_i;
  logic [NREQ-1:0] req_valid_i, req_ready_o;
  logic [NREQ*128-1:0] req_data_i;
  logic [127:0] red_p_o;
  logic [63:0] red_r_i, out_data_o;
  logic [1:0] out_id_o;
`ifdef RED_ARB_STATS_EN
  logic [NREQ*32-1:0] stats_acc_o;
  logic [31:0] stats_stall_o;
`endif
  int checks = 0, failures = 0, e = 0, nxt = 0, stall_n = 0;
  int acc [NREQ];
  int q_id [$];
  logic [63:0] q_dat [$];
  logic [127:0] rp [LAT];
  logic [63:0] mon_a, mon_e;
  logic [NREQ-1:0] xf;

  red_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .red_p_o(red_p_o), .red_ce_o(red_ce_o), .red_r_i(red_r_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
`ifdef RED_ARB_STATS_EN
    .stats_acc_o(stats_acc_o), .stats_stall_o(stats_stall_o),
`endif
    .out_id_o(out_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] modp(input logic [127:0] x);
    logic [127:0] m;
    m = x % {64'd0, P64};
    return m[63:0];
  endfunction

  function automatic logic [127:0] pat(input int n);
    logic [127:0] pp;
    pp = {64'd0, P64};
    if (n % 5 == 0) return pp;
    if (n % 5 == 1) return '1;
    if (n % 5 == 2) return pp - 128'd1;
    if (n % 5 == 3) return {64'(n), 64'hFFFF_FFFF_FFFF_FFFF};
    return {32'(n), 96'h0123_4567_89AB_CDEF_0F1E_2D3C};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_rst();
    rst_i = 1'b1;
    edge_();
    rst_i = 1'b0;
  endtask

  task automatic run_rr(input int n, input bit thru);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      chk("rr_grant", 128'(4'b0001 << (e % 4)), 128'(req_ready_o));
      if (thru && c >= LAT) chk("rr_thru", 128'(out_valid_o), 128'(1));
      edge_();
      req_data_i[128*(e%4) +: 128] = pat(nxt);
      nxt++;
      e++;
    end
  endtask

  // shared reducer model: LAT-deep, advances only with red_ce_o
  always @(posedge clk_i)
    if (red_ce_o) begin
      for (int i = LAT - 1; i > 0; i--) rp[i] <= rp[i-1];
      rp[0] <= red_p_o;
    end
  assign red_r_i = modp(rp[LAT-1]);

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (rst_i) begin
      q_id.delete();
      q_dat.delete();
      stall_n = 0;
      for (int i = 0; i < NREQ; i++) acc[i] = 0;
    end else begin
      chk("one_hot", 128'($countones(req_ready_o) <= 1), 128'(1));
      chk("ce", 128'(red_ce_o), 128'(!(out_valid_o && !out_ready_i)));
      for (int i = 0; i < NREQ; i++)
        if (req_valid_i[i] && req_ready_o[i]) begin
          q_id.push_back(i);
          q_dat.push_back(modp(req_data_i[128*i +: 128]));
          acc[i]++;
        end
      if (out_valid_o && !out_ready_i) stall_n++;
      if (out_valid_o && out_ready_i) begin
        if (q_id.size() == 0) chk("spurious_out", 128'(out_valid_o), 128'(0));
        else begin
          mon_e = q_dat.pop_front();
          mon_a = out_data_o;
          if (mon_a >= P64 && mon_a - P64 == mon_e) mon_a = mon_e;
          chk("res_id", 128'(out_id_o), 128'(q_id.pop_front()));
          chk("res_data", 128'(mon_a), 128'(mon_e));
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    req_valid_i = '1;
    req_data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 128'(req_ready_o), 128'(0));
    chk("rst_ce", 128'(red_ce_o), 128'(1));
    chk("rst_oval", 128'(out_valid_o), 128'(0));
    // single op from requester 2: 2^64 mod p = 2^32-1
    edge_();
    rst_i = 1'b0;
    req_valid_i = 4'b0100;
    req_data_i[2*128 +: 128] = 128'd1 << 64;
    @(negedge clk_i);
    chk("t1_grant", 128'(req_ready_o), 128'(4'b0100));
    edge_();
    req_valid_i = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk_i);
      chk("t1_lat", 128'(out_valid_o), 128'(k == LAT));
      if (k == LAT) begin
        chk("t1_data", 128'(out_data_o), 128'(64'hFFFF_FFFF));
        chk("t1_id", 128'(out_id_o), 128'(2));
      end
      edge_();
    end
    // all requesters busy: strict 0,1,2,3 rotation at one op per cycle
    pulse_rst();
    for (int i = 0; i < NREQ; i++) req_data_i[128*i +: 128] = pat(i);
    nxt = NREQ;
    e = 0;
    req_valid_i = '1;
    run_rr(16, 1'b1);
    // backpressure with a full pipeline
    out_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      chk("stall_ce", 128'(red_ce_o), 128'(0));
      chk("stall_ready", 128'(req_ready_o), 128'(0));
      edge_();
    end
    out_ready_i = 1'b1;
    run_rr(8, 1'b1);
    req_valid_i = '0;
    repeat (LAT + 2) edge_();
    // move rr_q to 2, then only 1 and 3 request
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    chk("rr2_setup", 128'(req_ready_o), 128'(4'b0010));
    edge_();
    req_valid_i = 4'b1010;
    @(negedge clk_i);
    chk("rr2_first", 128'(req_ready_o), 128'(4'b1000));
    edge_();
    @(negedge clk_i);
    chk("rr2_second", 128'(req_ready_o), 128'(4'b0010));
    edge_();
    req_valid_i = '0;
    repeat (LAT + 2) edge_();
    // reset with ops in flight
    req_valid_i = 4'b0001;
    repeat (3) edge_();
    req_valid_i = '0;
    pulse_rst();
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk_i);
      chk("flush_oval", 128'(out_valid_o), 128'(0));
      edge_();
    end
    pulse_rst();
    req_valid_i = 4'b0110;
    req_data_i[1*128 +: 128] = pat(3);
    @(negedge clk_i);
    chk("post_rst_grant", 128'(req_ready_o), 128'(4'b0010));
    edge_();
    req_valid_i = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk_i);
      chk("post_rst_lat", 128'(out_valid_o), 128'(k == LAT));
      if (k == LAT) chk("post_rst_id", 128'(out_id_o), 128'(1));
      edge_();
    end
    // random valids and backpressure
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_i);
      xf = req_valid_i & req_ready_o;
      edge_();
      for (int i = 0; i < NREQ; i++)
        if (xf[i] || !req_valid_i[i]) begin
          req_data_i[128*i +: 128] = (c % 7 == 0) ? pat(c + i) : {$urandom, $urandom, $urandom, $urandom};
          req_valid_i[i] = ($urandom % 2) == 0;
        end else req_valid_i[i] = ($urandom % 8) != 0;
      out_ready_i = ($urandom % 4) != 0;
    end
    req_valid_i = '0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 4 * LAT && q_id.size() != 0; c++) edge_();
    edge_();
    chk("drain_empty", 128'(q_id.size()), 128'(0));
`ifdef RED_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stats_acc", 128'(stats_acc_o[32*i +: 32]), 128'(acc[i]));
    chk("stats_stall", 128'(stats_stall_o), 128'(stall_n));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
